// File: rtl/regfile_sb.sv
// Multi-port register file with a one-bit-per-register reservation scoreboard.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module regfile_sb #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] ra_d,
    output logic [NRD-1:0]      ra_busy,
    input  logic [NWR-1:0]      wr,
    input  logic [NWR*AW-1:0]   rd,
    input  logic [NWR*XLEN-1:0] rd_d,
    input  logic                rsv,
    input  logic [AW-1:0]       rsv_addr,
    output logic [NREGS-1:0]    busy_vec
);

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    // Later loop iterations override earlier ones, so the highest-index write
    // port wins a collision and a reservation wins over a same-edge clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned n = 0; n < NREGS; n++) begin
                regs[n] <= '0;
            end
            busy <= '0;
        end else begin
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr[j] && (rd[j*AW +: AW] != '0)) begin
                    regs[rd[j*AW +: AW]] <= rd_d[j*XLEN +: XLEN];
                    busy[rd[j*AW +: AW]] <= 1'b0;
                end
            end
            if (rsv && (rsv_addr != '0)) begin
                busy[rsv_addr] <= 1'b1;
            end
        end
    end

    assign busy_vec = busy;

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] stored;

        assign addr   = ra[i*AW +: AW];
        assign stored = (addr == '0) ? '0 : regs[addr];

`ifdef REGFILE_BYPASS_EN
        logic            hit;
        logic [XLEN-1:0] wdata;

        always_comb begin
            hit   = 1'b0;
            wdata = '0;
            for (int unsigned j = 0; j < NWR; j++) begin
                if (wr[j] && (rd[j*AW +: AW] == addr)) begin
                    hit   = 1'b1;
                    wdata = rd_d[j*XLEN +: XLEN];
                end
            end
            // Nothing is forwarded while in reset or for the hard-wired zero register.
            if (rst || (addr == '0)) begin
                hit = 1'b0;
            end
        end

        assign ra_d[i*XLEN +: XLEN] = hit ? wdata : stored;
        assign ra_busy[i]           = hit ? (rsv && (rsv_addr == addr)) : busy[addr];
`else
        assign ra_d[i*XLEN +: XLEN] = stored;
        assign ra_busy[i]           = busy[addr];
`endif
    end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 XLEN, 32, data width in bits.
REQ-002 NREGS, 32, architectural register count; power of two, minimum 2; AW = log2(NREGS).
REQ-003 NRD, 2, number of read ports, range 1..4.
REQ-004 NWR, 1, number of write ports, range 1..2.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 ra  input  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-008 ra_d  output  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
REQ-009 ra_busy  output  NRD  port i address has a pending reservation.
REQ-010 wr  input  NWR  write enables, one per write port.
REQ-011 rd  input  NWR*AW  write addresses.
REQ-012 rd_d  input  NWR*XLEN  write data.
REQ-013 rsv  input  1  reserve request: marks rsv_addr pending.
REQ-014 rsv_addr  input  AW  register to reserve.
REQ-015 busy_vec  output  NREGS  full scoreboard state, bit n = register n pending.

Function
REQ-016 Register 0 SHALL always read 0; writes to and reservations of register 0 SHALL be ignored.
REQ-017 Write: on clock edge with wr[j]=1 and rd[j]!=0, REGS[rd[j]] SHALL take rd_d[j]; unaddressed registers SHALL hold.
REQ-018 Write collision: if several write ports target the same nonzero address in one cycle, the highest-index port SHALL win.
REQ-019 Read: ra_d port i SHALL be combinational from ra[i], zero cycles latency.
REQ-020 Scoreboard: on clock edge with rsv=1 and rsv_addr!=0, busy bit rsv_addr SHALL be set.
REQ-021 Any write to a nonzero address SHALL clear its busy bit on the same edge, whether or not it was set.
REQ-022 Simultaneous reserve and write to the same address SHALL leave the busy bit set (the new producer wins); the data write still occurs.
REQ-023 ra_busy[i] SHALL equal busy_vec[ra[i]], ignoring any same-cycle write unless bypass is compiled in (REQ-028).
REQ-024 Reservations SHALL not affect stored data; a reserved register SHALL read its last written value.
REQ-025 Reserving an already-busy register SHALL leave it busy (no counting; single bit per register).

Reset
REQ-026 While rst=1, all REGS SHALL be 0 and busy_vec SHALL be all 0, immediately and independent of clk; ra_d SHALL therefore read 0 and ra_busy SHALL be 0.
REQ-027 A write or reserve coincident with rst assertion or deassertion edge SHALL be discarded; the first update SHALL occur on the first rising clk edge with rst=0.

Configuration
REQ-028 With REGFILE_BYPASS_EN defined: when a same-cycle write (winning per REQ-018) targets nonzero ra[i], ra_d port i SHALL return that write's rd_d and ra_busy[i] SHALL read 0, unless rsv targets the same address that cycle, in which case ra_busy[i] SHALL read 1.
REQ-029 Without REGFILE_BYPASS_EN: ra_d and ra_busy SHALL reflect only stored state; the written value SHALL be visible the cycle after the write edge.

Verification
REQ-030 Assert rst mid-run after writing REGS[5]=0xDEADBEEF and reserving reg 7 -> ra_d=0 and busy_vec=0 before the next clk edge.
REQ-031 wr[0]=1, rd=0, rd_d=0x12345678 -> reading ra=0 returns 0; busy_vec[0] stays 0.
REQ-032 NWR=2, both ports write reg 3 (0x11 on port 0, 0x22 on port 1) -> reg 3 reads 0x22 the next cycle.
REQ-033 rsv reg 9; next cycle write 0xA5A5A5A5 to reg 9 -> ra_busy=1 for one cycle, then 0 with data 0xA5A5A5A5; with bypass, the write cycle reads data 0xA5A5A5A5 and busy 0.
REQ-034 Same-cycle rsv and write to reg 4 -> busy_vec[4]=1 and reg 4 holds the new data after the edge.
REQ-035 Build both with and without REGFILE_BYPASS_EN; read reg 6 while writing 0x77 with old value 0x66 -> 0x77 with the macro, 0x66 without.
